// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter for N=2**W requesters: registered one-hot grant and binary index,
// held until release, request drop, or hold timeout.
module onehot_rr_arbiter #(
    parameter int unsigned W       = 4,
    parameter int unsigned CW      = 8,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [2**W-1:0]   req,
    input  logic              rel,
    output logic              gnt_valid,
    output logic [2**W-1:0]   gnt_onehot,
    output logic [W-1:0]      gnt_idx,
    output logic              timeout
);
    localparam int unsigned N = 2**W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_d;
    logic [N-1:0]    onehot_d;
    logic [W-1:0]    idx_d;
    logic [W-1:0]    last, last_d;
    logic [CW-1:0]   hold_cnt, hold_cnt_d;
    logic            timeout_d;
    logic [W-1:0]    pick, cand;
    logic            found;
    logic            release_now, expire_now;

    // Search last+1, last+2, ... wrapping; W-bit addition gives the mod-N wrap.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = last + W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign release_now = rel | ~req[gnt_idx];
    assign expire_now  = (MAXHOLD != 0) && (hold_cnt == CW'(MAXHOLD));

    always_comb begin
        state_d    = state;
        onehot_d   = gnt_onehot;
        idx_d      = gnt_idx;
        last_d     = last;
        hold_cnt_d = hold_cnt;
        timeout_d  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d    = BUSY;
                    onehot_d   = N'(1) << pick;
                    idx_d      = pick;
                    hold_cnt_d = CW'(1);
                end
            end
            BUSY: begin
                if (release_now || expire_now) begin
                    state_d    = IDLE;
                    onehot_d   = '0;
                    last_d     = gnt_idx;
                    hold_cnt_d = '0;
                    timeout_d  = ~release_now;
                end else if (hold_cnt != '1) begin
                    hold_cnt_d = hold_cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            gnt_onehot <= '0;
            gnt_idx    <= '0;
            last       <= '1;
            hold_cnt   <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_d;
            gnt_onehot <= onehot_d;
            gnt_idx    <= idx_d;
            last       <= last_d;
            hold_cnt   <= hold_cnt_d;
            timeout    <= timeout_d;
        end
    end

    assign gnt_valid = (state == BUSY);

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter: vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_onehot_rr_arbiter;
    localparam int MAXH = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] req;
    logic        rel;
    logic        gnt_valid;
    logic [15:0] gnt_onehot;
    logic [3:0]  gnt_idx;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    onehot_rr_arbiter #(.W(4), .CW(8), .MAXHOLD(MAXH)) dut (
        .clk(clk), .rstn(rstn), .req(req), .rel(rel),
        .gnt_valid(gnt_valid), .gnt_onehot(gnt_onehot),
        .gnt_idx(gnt_idx), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // behavioural model state: current owner (or none), pointer, hold length
    bit m_busy;
    int m_owner, m_last, m_hold, m_idx;
    bit m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mpick(input logic [15:0] r, input int lst);
        for (int k = 1; k <= 16; k++)
            if (r[(lst + k) % 16]) return (lst + k) % 16;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 15; m_hold = 0; m_idx = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [15:0] r, input logic rl);
        bit relb, exp;
        int p;
        if (!m_busy) begin
            m_to = 0;
            p = mpick(r, m_last);
            if (p >= 0) begin
                m_busy = 1; m_owner = p; m_idx = p; m_hold = 1;
            end
        end else begin
            relb = rl || !r[m_owner];
            exp  = (MAXH != 0) && (m_hold == MAXH);
            if (relb || exp) begin
                m_busy = 0; m_last = m_owner; m_to = !relb; m_hold = 0;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic [15:0] r, input logic rl);
        req = r;
        rel = rl;
        model_step(r, rl);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},  32'(gnt_valid), 32'(m_busy));
        check({tag, ".onehot"}, 32'(gnt_onehot), m_busy ? (32'd1 << m_owner) : 32'd0);
        check({tag, ".idx"},    32'(gnt_idx), 32'(m_idx));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    // structural invariants sampled on the falling edge
    logic       prev_valid = 1'b0;
    logic [3:0] prev_idx   = '0;
    always @(negedge clk) begin
        if (rstn) begin
            if (!$onehot0(gnt_onehot)) check("inv.onehot0", 32'(gnt_onehot), 32'd0);
            if (!gnt_valid && gnt_onehot != 0) check("inv.idle_nogrant", 32'(gnt_onehot), 32'd0);
            if (gnt_valid && gnt_onehot != (16'd1 << gnt_idx))
                check("inv.onehot_idx", 32'(gnt_onehot), 32'(16'd1 << gnt_idx));
            if (prev_valid && gnt_valid && gnt_idx != prev_idx)
                check("inv.gap", 32'(gnt_idx), 32'(prev_idx));
        end
        prev_valid = gnt_valid;
        prev_idx   = gnt_idx;
    end

    typedef struct {
        logic [15:0] r;
        logic        rl;
        logic        v;
        logic [3:0]  idx;
        logic        to;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int n;
        logic [15:0] rr;
        logic [15:0] eoh;

        // reset ptr=15: 0 first, then 5,10,15,0 round robin, then implicit release
        tbl[0]  = '{16'h0001, 1'b0, 1'b1, 4'd0,  1'b0};
        tbl[1]  = '{16'h0001, 1'b1, 1'b0, 4'd0,  1'b0};
        tbl[2]  = '{16'h8421, 1'b0, 1'b1, 4'd5,  1'b0};
        tbl[3]  = '{16'h8421, 1'b1, 1'b0, 4'd5,  1'b0};
        tbl[4]  = '{16'h8421, 1'b0, 1'b1, 4'd10, 1'b0};
        tbl[5]  = '{16'h8421, 1'b1, 1'b0, 4'd10, 1'b0};
        tbl[6]  = '{16'h8421, 1'b0, 1'b1, 4'd15, 1'b0};
        tbl[7]  = '{16'h8421, 1'b1, 1'b0, 4'd15, 1'b0};
        tbl[8]  = '{16'h8421, 1'b0, 1'b1, 4'd0,  1'b0};
        tbl[9]  = '{16'h8421, 1'b1, 1'b0, 4'd0,  1'b0};
        tbl[10] = '{16'h0008, 1'b0, 1'b1, 4'd3,  1'b0};
        tbl[11] = '{16'h0000, 1'b0, 1'b0, 4'd3,  1'b0};
        tbl[12] = '{16'h0018, 1'b0, 1'b1, 4'd4,  1'b0};
        tbl[13] = '{16'h0000, 1'b0, 1'b0, 4'd4,  1'b0};
        tbl[14] = '{16'h0000, 1'b1, 1'b0, 4'd4,  1'b0};

        rstn = 1'b0; req = '0; rel = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid",   32'(gnt_valid), 32'd0);
        check("reset.onehot",  32'(gnt_onehot), 32'd0);
        check("reset.idx",     32'(gnt_idx), 32'd0);
        check("reset.timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].rl);
            eoh = tbl[i].v ? (16'd1 << tbl[i].idx) : 16'd0;
            check($sformatf("tbl%0d.valid", i),   32'(gnt_valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d.onehot", i),  32'(gnt_onehot), 32'(eoh));
            check($sformatf("tbl%0d.idx", i),     32'(gnt_idx), 32'(tbl[i].idx));
            check($sformatf("tbl%0d.timeout", i), 32'(timeout), 32'(tbl[i].to));
        end

        // hold timeout: req[1] held, no rel -> exactly MAXH valid cycles
        step(16'h0002, 1'b0);
        check("to.grant_idx", 32'(gnt_idx), 32'd1);
        n = 0;
        while (gnt_valid && n < 40) begin
            n++;
            step(16'h0002, 1'b0);
        end
        check("to.held_cycles", 32'(n), 32'(MAXH));
        check("to.pulse",       32'(timeout), 32'd1);
        check("to.revoked",     32'(gnt_valid), 32'd0);
        step(16'h0002, 1'b0);
        check("to.pulse_end",   32'(timeout), 32'd0);
        check("to.regrant",     32'(gnt_valid), 32'd1);
        check("to.regrant_idx", 32'(gnt_idx), 32'd1);

        // rel in the last allowed held cycle wins over the timeout
        repeat (MAXH - 1) step(16'h0002, 1'b0);
        check("edge.still_held", 32'(gnt_valid), 32'd1);
        step(16'h0002, 1'b1);
        check("edge.released", 32'(gnt_valid), 32'd0);
        check("edge.no_timeout", 32'(timeout), 32'd0);

        // async reset mid-grant, then pointer back to N-1
        step(16'hFFFF, 1'b0);
        check("rst.pre_valid", 32'(gnt_valid), 32'd1);
        check("rst.pre_idx",   32'(gnt_idx), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("rst.async_valid",  32'(gnt_valid), 32'd0);
        check("rst.async_onehot", 32'(gnt_onehot), 32'd0);
        check("rst.async_idx",    32'(gnt_idx), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        step(16'hFFFF, 1'b0);
        check("rst.first_idx", 32'(gnt_idx), 32'd0);
        check_model("rst");

        // randomized traffic, requests mostly stable so timeouts occur
        rr = 16'($urandom);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) rr = 16'($urandom) & 16'($urandom);
            step(rr, ($urandom_range(0, 5) == 0));
            check_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
